apb4_archinfo_ext: RTL and testbench

Parametrised APB4 architecture-information block holding a SYS word and NUM_ID identification words. Adds over the prior archinfo generation: a sticky write-lock, a 64-bit free-running cycle counter with an atomic high-word snapshot, sticky error status, and unmapped-address detection. Sits on the peripheral APB4 bus; firmware reads platform identity and uptime from it.

---
 rtl/apb4_archinfo_ext.sv | 176 +++++++++++++++++
 tb/tb_apb4_archinfo_ext.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_archinfo_ext.sv
// apb4_archinfo_ext: APB4 architecture-information block.
// Holds a SYS word and NUM_ID identification words. It also provides a sticky
// write-lock, a 64-bit cycle counter with an atomic high-word snapshot,
// sticky error status and detection of unmapped addresses.
// Optional build macro: ARCHINFO_PSLVERR_EN. When it is defined, an erroneous
// access is answered with pslverr. When it is undefined, pslverr is tied low
// and the error is only recorded in STAT.WERR.
module apb4_archinfo_ext #(
  parameter int unsigned          NUM_ID  = 4,
  parameter logic [31:0]          SYS_VAL = 32'h0,
  parameter logic [NUM_ID*32-1:0] ID_VAL  = '0,
  parameter int unsigned          ADDR_W  = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int unsigned IW = ADDR_W - 2;

  localparam logic [IW-1:0] IDX_SYS  = IW'(32'd0);
  localparam logic [IW-1:0] IDX_CTRL = IW'(32'd1);
  localparam logic [IW-1:0] IDX_STAT = IW'(32'd2);
  localparam logic [IW-1:0] IDX_CNTL = IW'(32'd3);
  localparam logic [IW-1:0] IDX_CNTH = IW'(32'd4);
  localparam int unsigned   IDX_ID0  = 32'd8;

  logic [31:0]       sys_r;
  logic [31:0]       id_r [NUM_ID];
  logic              lock_r;
  logic              cnt_en_r;
  logic              werr_r;
  logic [63:0]       cnt_r;
  logic [31:0]       shadow_hi_r;

  logic [IW-1:0]     idx_s;
  logic              access_s;
  logic              rd_s;
  logic              wr_ok_s;
  logic              is_sys_s, is_ctrl_s, is_stat_s, is_cntl_s, is_cnth_s, is_id_s;
  logic              mapped_s;
  logic              err_s;
  logic [NUM_ID-1:0] id_hit_s;
  logic [31:0]       id_rdata_s;
  logic [31:0]       rdata_s;
  logic              unused_ok_s;

  assign idx_s       = paddr[ADDR_W-1:2];
  assign unused_ok_s = ^paddr[1:0];
  assign access_s    = psel & penable;
  assign rd_s        = access_s & ~pwrite;

  assign is_sys_s  = (idx_s == IDX_SYS);
  assign is_ctrl_s = (idx_s == IDX_CTRL);
  assign is_stat_s = (idx_s == IDX_STAT);
  assign is_cntl_s = (idx_s == IDX_CNTL);
  assign is_cnth_s = (idx_s == IDX_CNTH);

  // ID window decode and read selection
  always_comb begin
    id_hit_s   = '0;
    id_rdata_s = 32'h0;
    for (int i = 0; i < NUM_ID; i++) begin
      id_hit_s[i] = (idx_s == IW'(IDX_ID0 + 32'(i)));
      id_rdata_s  = id_rdata_s | (id_hit_s[i] ? id_r[i] : 32'h0);
    end
  end

  assign is_id_s  = |id_hit_s;
  assign mapped_s = is_sys_s | is_ctrl_s | is_stat_s | is_cntl_s | is_cnth_s | is_id_s;

  // Error: unmapped access, locked write to SYS/ID, or write to a read-only counter word
  assign err_s = access_s & (~mapped_s
                           | (pwrite & lock_r & (is_sys_s | is_id_s))
                           | (pwrite & (is_cntl_s | is_cnth_s)));

  // An erroneous write never changes state
  assign wr_ok_s = access_s & pwrite & ~err_s;

  // Configuration registers: SYS, ID words, sticky LOCK and CNT_EN
  always_ff @(posedge pclk) begin
    if (preset) begin
      sys_r    <= SYS_VAL;
      lock_r   <= 1'b0;
      cnt_en_r <= 1'b0;
      for (int i = 0; i < NUM_ID; i++) begin
        id_r[i] <= ID_VAL[32*i +: 32];
      end
    end else begin
      if (wr_ok_s && is_sys_s) begin
        sys_r <= pwdata;
      end
      for (int i = 0; i < NUM_ID; i++) begin
        if (wr_ok_s && id_hit_s[i]) begin
          id_r[i] <= pwdata;
        end
      end
      if (wr_ok_s && is_ctrl_s) begin
        lock_r   <= lock_r | pwdata[0];
        cnt_en_r <= pwdata[1];
      end
    end
  end

  // Free-running 64-bit counter; a clear request beats the increment
  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_r <= 64'h0;
    end else if (wr_ok_s && is_ctrl_s && pwdata[2]) begin
      cnt_r <= 64'h0;
    end else if (cnt_en_r) begin
      cnt_r <= cnt_r + 64'd1;
    end
  end

  // Capture the high word when the low word is read, so a CNTL/CNTH pair is coherent
  always_ff @(posedge pclk) begin
    if (preset) begin
      shadow_hi_r <= 32'h0;
    end else if (rd_s && is_cntl_s) begin
      shadow_hi_r <= cnt_r[63:32];
    end
  end

  // Sticky write-error flag; a new error outranks a simultaneous clear
  always_ff @(posedge pclk) begin
    if (preset) begin
      werr_r <= 1'b0;
    end else if (err_s) begin
      werr_r <= 1'b1;
    end else if (wr_ok_s && is_stat_s && pwdata[1]) begin
      werr_r <= 1'b0;
    end
  end

  // Read data mux; zero outside a read access and for unmapped offsets
  always_comb begin
    rdata_s = 32'h0;
    if (rd_s) begin
      if (is_sys_s) begin
        rdata_s = sys_r;
      end else if (is_ctrl_s) begin
        rdata_s = {30'h0, cnt_en_r, lock_r};
      end else if (is_stat_s) begin
        rdata_s = {30'h0, werr_r, lock_r};
      end else if (is_cntl_s) begin
        rdata_s = cnt_r[31:0];
      end else if (is_cnth_s) begin
        rdata_s = shadow_hi_r;
      end else if (is_id_s) begin
        rdata_s = id_rdata_s;
      end else begin
        rdata_s = 32'h0;
      end
    end else begin
      rdata_s = 32'h0;
    end
  end

  assign prdata = rdata_s;
  assign pready = 1'b1;

`ifdef ARCHINFO_PSLVERR_EN
  assign pslverr = err_s;
`else
  assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb4_archinfo_ext.sv
// Scoreboard testbench for apb4_archinfo_ext with a transaction-level reference model.
module tb_apb4_archinfo_ext;

  localparam int NUM_ID = 4;
  localparam logic [31:0] SYS_VAL = 32'h0001_0203;
  localparam logic [NUM_ID*32-1:0] ID_VAL =
    {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'hA5A5_0000};
`ifdef ARCHINFO_PSLVERR_EN
  localparam bit PSLV = 1'b1;
`else
  localparam bit PSLV = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [7:0]  paddr = 8'h0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  always #5 pclk = ~pclk;

  apb4_archinfo_ext #(
    .NUM_ID(NUM_ID), .SYS_VAL(SYS_VAL), .ID_VAL(ID_VAL), .ADDR_W(8)
  ) dut (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    logic [7:0]  addr;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;
  longint unsigned cyc = 0;

  // Edge counter used by the model to reason about elapsed cycles
  always @(posedge pclk) cyc <= cyc + 64'd1;

  // Reference model state
  logic [31:0]     m_sys;
  logic [31:0]     m_id [NUM_ID];
  bit              m_lock, m_en, m_werr;
  longint unsigned m_base, m_since;
  logic [31:0]     m_shadow;
  bit              m_force_on = 1'b0;
  longint unsigned m_force_val = 64'h0;

  // Counter value after edge c: a base loaded at edge m_since plus elapsed enabled cycles
  function automatic longint unsigned cnt_at(longint unsigned c);
    if (m_force_on) return m_force_val;
    return m_en ? m_base + (c - m_since) : m_base;
  endfunction

  function automatic void m_reset();
    m_sys = SYS_VAL;
    for (int i = 0; i < NUM_ID; i++) m_id[i] = ID_VAL[32*i +: 32];
    m_lock = 1'b0; m_en = 1'b0; m_werr = 1'b0;
    m_base = 64'h0; m_since = cyc; m_shadow = 32'h0;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops one expectation per access phase; outside accesses prdata must be 0
  always @(negedge pclk) begin
    exp_t e;
    check("pready", {31'h0, pready}, 32'h1);
    if (psel && penable) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_empty: access at addr %h with no expectation", paddr);
      end else begin
        e = sbq.pop_front();
        check($sformatf("prdata@%h", e.addr), prdata, e.rdata);
        check($sformatf("pslverr@%h", e.addr), {31'h0, pslverr}, {31'h0, e.slverr});
      end
    end else begin
      check("idle_prdata", prdata, 32'h0);
    end
  end

  // One APB transfer; the expectation is computed from the model at the access phase
  task automatic apb(input logic [7:0] addr, input bit wr, input logic [31:0] data,
                     input bit rst_mid = 1'b0);
    int idx;
    bit id_hit, mapped, err;
    logic [31:0] rd;
    longint unsigned v, v2;
    exp_t e;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    if (rst_mid) preset = 1'b1;
    idx = int'(addr[7:2]);
    id_hit = (idx >= 8) && (idx < 8 + NUM_ID);
    mapped = (idx <= 4) || id_hit;
    err = !mapped || (wr && m_lock && (idx == 0 || id_hit)) || (wr && (idx == 3 || idx == 4));
    v = cnt_at(cyc);
    rd = 32'h0;
    if (!wr && mapped) begin
      case (idx)
        0: rd = m_sys;
        1: rd = {30'h0, m_en, m_lock};
        2: rd = {30'h0, m_werr, m_lock};
        3: rd = v[31:0];
        4: rd = m_shadow;
        default: rd = m_id[idx-8];
      endcase
    end
    e.rdata = rd; e.slverr = PSLV & err; e.addr = addr;
    sbq.push_back(e);
    @(posedge pclk); #1;
    if (rst_mid) begin
      m_reset();
      preset = 1'b0;
    end else begin
      if (!wr && idx == 3) m_shadow = v[63:32];
      if (err) begin
        m_werr = 1'b1;
      end else if (wr) begin
        case (idx)
          0: m_sys = data;
          1: begin
            v2 = cnt_at(cyc);
            m_base = data[2] ? 64'h0 : v2;
            m_since = cyc;
            m_en = data[1];
            m_lock = m_lock | data[0];
          end
          2: if (data[1]) m_werr = 1'b0;
          default: if (id_hit) m_id[idx-8] = data;
        endcase
      end
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  // Setup phase that is abandoned before the access phase: must not touch state
  task automatic setup_only(input logic [7:0] addr, input bit wr, input logic [31:0] data);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
    @(posedge pclk); #1;
    psel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
  endtask

  int mapped_idx [9] = '{0, 1, 2, 3, 4, 8, 9, 10, 11};

  initial begin
    int idx, wait_cnt;
    bit wr;
    logic [31:0] data;
    logic [1:0] lo;

    // Reset
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    m_reset();
    preset = 1'b0;

    // Reset values
    apb(8'h00, 1'b0, 32'h0);
    apb(8'h20, 1'b0, 32'h0);
    apb(8'h08, 1'b0, 32'h0);
    apb(8'h04, 1'b0, 32'h0);
    idle(2);

    // Counter run and clear
    apb(8'h04, 1'b1, 32'h2);
    idle(10);
    apb(8'h0C, 1'b0, 32'h0);
    apb(8'h04, 1'b1, 32'h6);
    apb(8'h0C, 1'b0, 32'h0);
    apb(8'h10, 1'b0, 32'h0);

    // Snapshot atomicity across a carry into the high word
    apb(8'h04, 1'b1, 32'h4);
    @(posedge pclk); #1;
    force dut.cnt_r = 64'h0000_0000_FFFF_FFFF;
    m_force_on = 1'b1; m_force_val = 64'h0000_0000_FFFF_FFFF;
    apb(8'h0C, 1'b0, 32'h0);
    force dut.cnt_r = 64'h0000_0001_0000_0004;
    m_force_val = 64'h0000_0001_0000_0004;
    idle(5);
    apb(8'h10, 1'b0, 32'h0);
    release dut.cnt_r;
    m_force_on = 1'b0;
    apb(8'h04, 1'b1, 32'h6);

    // Unmapped read, write to read-only counter, WERR set and clear
    apb(8'h40, 1'b0, 32'h0);
    apb(8'h0C, 1'b1, 32'h0000_0123);
    apb(8'h08, 1'b0, 32'h0);
    apb(8'h08, 1'b1, 32'h2);
    apb(8'h08, 1'b0, 32'h0);

    // Lock behaviour
    apb(8'h24, 1'b1, 32'hDEAD_BEEF);
    apb(8'h04, 1'b1, 32'h1);
    apb(8'h24, 1'b1, 32'h1234_5678);
    apb(8'h24, 1'b0, 32'h0);
    apb(8'h08, 1'b0, 32'h0);
    apb(8'h00, 1'b1, 32'h5555_AAAA);
    apb(8'h00, 1'b0, 32'h0);

    // Reset during a write access
    apb(8'h00, 1'b1, 32'hCAFE_F00D, 1'b1);
    apb(8'h00, 1'b0, 32'h0);
    apb(8'h04, 1'b0, 32'h0);
    apb(8'h0C, 1'b0, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 6) idx = mapped_idx[$urandom_range(0, 8)];
      else idx = int'($urandom_range(0, 63));
      wr = 1'($urandom_range(0, 1));
      data = $urandom;
      lo = 2'($urandom_range(0, 3));
      if (idx == 1) begin
        data[0] = ($urandom_range(0, 29) == 0);
        data[1] = ($urandom_range(0, 3) != 0);
        data[2] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 9) == 0) setup_only({idx[5:0], lo}, wr, data);
      else apb({idx[5:0], lo}, wr, data);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 4)));
    end

    // Drain with a bounded wait
    wait_cnt = 0;
    while (sbq.size() != 0 && wait_cnt < 20) begin
      @(posedge pclk);
      wait_cnt++;
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sbq.size());
    end
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
